// File: rtl/parity_stream_pkg.sv
// Shared types and constants for the streaming parity generator/checker.
package parity_stream_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    GEN_TRL = 2'd2,
    CHK_TRL = 2'd3
  } state_t;

  // ctrl encoding
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // odd_sel encoding
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_bit_calc.sv
// Combinational parity bit: word plus par has an even (odd=0) or odd (odd=1)
// number of ones.
module parity_bit_calc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] word,
  input  logic              odd,
  output logic              par
);

  assign par = (^word) ^ odd;

endmodule

// File: rtl/parity_stream_gen_check.sv
// Streaming parity generator/checker with a per-frame LRC trailer beat.
// Handshake: a beat transfers on a rising edge where valid & ready are both 1;
// valid never depends on ready, and while out_valid=1 and out_ready=0 every
// out_* field holds stable.
module parity_stream_gen_check
  import parity_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl,
  input  logic                 odd_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_par,
  output logic                 out_lrc,
  output logic                 word_err,
  output logic                 frame_err,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_t            state;
  logic              mode_chk;
  logic              mode_odd;
  logic [DATA_W-1:0] lrc;
  logic [CNT_W-1:0]  cnt;

  logic              out_free;
  logic              accept;
  logic              eff_chk;
  logic              eff_odd;
  logic              word_par;
  logic              lrc_par;
  logic [DATA_W-1:0] lrc_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              last_word;
  logic              load_trl;

  logic              ld;
  logic [DATA_W-1:0] ld_data;
  logic              ld_par;
  logic              ld_lrc;
  logic              ld_werr;
  logic              ld_ferr;

  // Output register can take a new beat when empty or being drained this cycle
  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && (state != GEN_TRL) && out_free;
  assign accept   = in_valid && in_ready;

  // In IDLE the mode inputs apply directly to the first word of the frame
  assign eff_chk = (state == IDLE) ? ctrl    : mode_chk;
  assign eff_odd = (state == IDLE) ? odd_sel : mode_odd;

  assign lrc_next  = (state == IDLE) ? in_data : (lrc ^ in_data);
  assign cnt_next  = (state == IDLE) ? CNT_W'(1) : (cnt + CNT_W'(1));
  assign last_word = (cnt_next == CNT_W'(FRAME_LEN));
  assign load_trl  = (state == GEN_TRL) && out_free;

  parity_bit_calc #(.DATA_W(DATA_W)) u_word_par (
    .word (in_data),
    .odd  (eff_odd),
    .par  (word_par)
  );

  parity_bit_calc #(.DATA_W(DATA_W)) u_lrc_par (
    .word (lrc),
    .odd  (mode_odd),
    .par  (lrc_par)
  );

  // Next output-register contents for a generated trailer or an accepted beat
  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_par  = 1'b0;
    ld_lrc  = 1'b0;
    ld_werr = 1'b0;
    ld_ferr = 1'b0;
    if (load_trl) begin
      ld      = 1'b1;
      ld_data = lrc;
      ld_par  = lrc_par;
      ld_lrc  = 1'b1;
    end else if (accept) begin
      ld      = 1'b1;
      ld_data = in_data;
      if (state == CHK_TRL) begin
        // Received LRC beat: its parity bit carries no meaning, only echoed
        ld_par  = in_par;
        ld_lrc  = 1'b1;
        ld_ferr = (in_data != lrc);
      end else if (eff_chk == MODE_CHK) begin
        ld_par  = in_par;
        ld_werr = (in_par != word_par);
      end else begin
        ld_par  = word_par;
      end
    end
  end

  // Frame FSM, LRC accumulator, word counter and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_chk  <= MODE_GEN;
      mode_odd  <= PAR_EVEN;
      lrc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_par   <= 1'b0;
      out_lrc   <= 1'b0;
      word_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= ld_data;
        out_par   <= ld_par;
        out_lrc   <= ld_lrc;
        word_err  <= ld_werr;
        frame_err <= ld_ferr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            if (state == IDLE) begin
              mode_chk <= ctrl;
              mode_odd <= odd_sel;
            end
            lrc <= lrc_next;
            cnt <= cnt_next;
            if (last_word) begin
              state <= (eff_chk == MODE_CHK) ? CHK_TRL : GEN_TRL;
            end else begin
              state <= DATA;
            end
          end
        end
        GEN_TRL: begin
          if (out_free) begin
            lrc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        CHK_TRL: begin
          if (accept) begin
            lrc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating error counter; clear takes priority over a same-cycle event
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      err_cnt <= '0;
    end else if (ld && (ld_werr || ld_ferr) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_stream_gen_check.sv
// Bench for parity_stream_gen_check: expected output beats are queued when
// stimulus is driven and compared by a monitor as the sink accepts them.
module tb_parity_stream_gen_check;

  logic       clk;
  logic       rst;
  logic       ctrl;
  logic       odd_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_par;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_par;
  logic       out_lrc;
  logic       word_err;
  logic       frame_err;
  logic       clr_cnt;
  logic [7:0] err_cnt;

  // Narrow-counter instance, fed the same stream, for saturation
  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_data2;
  logic       out_par2;
  logic       out_lrc2;
  logic       word_err2;
  logic       frame_err2;
  logic [1:0] err_cnt2;

  int tests;
  int fails;

  // {data, par, lrc, word_err, frame_err}
  logic [11:0] exp_q[$];

  logic [7:0] w[4];

  parity_stream_gen_check #(.DATA_W(8), .FRAME_LEN(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .odd_sel(odd_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par(out_par), .out_lrc(out_lrc), .word_err(word_err),
    .frame_err(frame_err), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  parity_stream_gen_check #(.DATA_W(8), .FRAME_LEN(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .odd_sel(odd_sel),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_par(out_par2), .out_lrc(out_lrc2), .word_err(word_err2),
    .frame_err(frame_err2), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each accepted output beat with the queue head
  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got = {out_data, out_par, out_lrc, word_err, frame_err};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected got=%h required=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL beat got data=%h par=%b lrc=%b werr=%b ferr=%b required data=%h par=%b lrc=%b werr=%b ferr=%b",
                   got[11:4], got[3], got[2], got[1], got[0], e[11:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic p, input logic l,
                          input logic we, input logic fe);
    exp_q.push_back({d, p, l, we, fe});
  endtask

  // Drive one input beat (called just after a rising edge) and wait for accept
  task automatic send_word(input logic [7:0] d, input logic p, input logic c, input logic o);
    int  n;
    logic acc;
    in_data  = d;
    in_par   = p;
    ctrl     = c;
    odd_sel  = o;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL accept_timeout data=%h got=no_accept required=accept", d);
    end
  endtask

  // Wait for the scoreboard to empty, bounded
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got=%0d pending required=0", name, exp_q.size());
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp_cnt);
    @(negedge clk);
    tests++;
    if (err_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL %s_err_cnt got=%0d required=%0d", name, err_cnt, exp_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_par, out_lrc, word_err, frame_err, err_cnt, in_ready} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state got v=%b d=%h p=%b l=%b we=%b fe=%b cnt=%h rdy=%b required all 0",
               out_valid, out_data, out_par, out_lrc, word_err, frame_err, err_cnt, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gen_even();
    logic ep[4];
    ep = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push_exp(w[i], ep[i], 1'b0, 1'b0, 1'b0);
      if (i == 3) push_exp(8'hFA, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(w[i], 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL gen_even_trailer_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    drain("gen_even");
  endtask

  task automatic test_gen_odd();
    logic ep[4];
    ep = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      push_exp(w[i], ep[i], 1'b0, 1'b0, 1'b0);
      if (i == 3) push_exp(8'hFA, 1'b1, 1'b1, 1'b0, 1'b0);
      send_word(w[i], 1'b0, 1'b0, 1'b1);
    end
    drain("gen_odd");
  endtask

  // Check-mode frame; pars are the received parity bits, werr the expected flags
  task automatic check_frame(input logic p0, input logic p1, input logic p2, input logic p3,
                             input logic [7:0] trl, input string name);
    logic pp[4];
    logic good[4];
    pp   = '{p0, p1, p2, p3};
    good = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push_exp(w[i], pp[i], 1'b0, pp[i] != good[i], 1'b0);
      send_word(w[i], pp[i], 1'b1, 1'b0);
    end
    push_exp(trl, 1'b0, 1'b1, 1'b0, trl != 8'hFA);
    send_word(trl, 1'b0, 1'b1, 1'b0);
    drain(name);
  endtask

  task automatic test_check_clean();
    check_frame(1'b1, 1'b0, 1'b1, 1'b0, 8'hFA, "check_clean");
    check_cnt("check_clean", 8'd0);
  endtask

  task automatic test_check_corrupt();
    check_frame(1'b1, 1'b1, 1'b1, 1'b0, 8'hFB, "check_corrupt");
    check_cnt("check_corrupt", 8'd2);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check_cnt("check_clr", 8'd0);
  endtask

  task automatic test_backpressure();
    logic ep[4];
    ep = '{1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(w[i], ep[i], 1'b0, 1'b0, 1'b0);
    push_exp(8'hFA, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(w[0], 1'b0, 1'b0, 1'b0);
    in_data  = w[1];
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || out_par !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b d=%h p=%b rdy=%b required v=1 d=01 p=1 rdy=0",
                 c, out_valid, out_data, out_par, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) send_word(w[i], 1'b0, 1'b0, 1'b0);
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    push_exp(w[0], 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(w[1], 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(w[0], 1'b0, 1'b0, 1'b0);
    send_word(w[1], 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_par, out_lrc, word_err, frame_err, err_cnt, in_ready} !== 21'd0) begin
      fails++;
      $display("FAIL reset_mid_state got v=%b d=%h p=%b l=%b cnt=%h rdy=%b required all 0",
               out_valid, out_data, out_par, out_lrc, err_cnt, in_ready);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_pending got=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_gen_even();
  endtask

  task automatic test_saturate();
    check_frame(1'b1, 1'b1, 1'b1, 1'b0, 8'hFB, "sat1");
    check_frame(1'b1, 1'b1, 1'b1, 1'b0, 8'hFB, "sat2");
    check_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'hFA, "sat3");
    check_cnt("saturate_wide", 8'd5);
    @(negedge clk);
    tests++;
    if (err_cnt2 !== 2'd3) begin
      fails++;
      $display("FAIL saturate_narrow_err_cnt got=%0d required=3", err_cnt2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    w = '{8'h01, 8'h03, 8'h07, 8'hFF};
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    ctrl      = 1'b0;
    odd_sel   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_par    = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_gen_even();
    test_gen_odd();
    test_check_clean();
    test_check_corrupt();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_stream_gen_check.md
Name: parity_stream_gen_check

Overview:
Parametrised, streaming parity generator/checker with frame-level longitudinal redundancy check (LRC).
- Generate mode: appends a per-word parity bit to each word, then emits an LRC trailer beat after every FRAME_LEN words.
- Check mode: verifies per-word parity and the received LRC trailer, and keeps a saturating error count.
- Sits between a valid/ready word source and sink; successor to the 4-bit combinational parity_gen_check.

Parameters:
DATA_W, 8, word width in bits (>=1)
FRAME_LEN, 4, data words per frame before the LRC trailer (>=1)
ERR_CNT_W, 8, width of the saturating error counter (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ctrl  in  1  mode: 0 = generate, 1 = check; sampled on first word of each frame
odd_sel  in  1  0 = even parity, 1 = odd parity; sampled with ctrl
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  DATA_W  input word (in check mode, the trailer beat carries the received LRC)
in_par  in  1  received parity bit (check mode only; ignored on trailer beat)
out_valid  out  1  output beat valid
out_ready  in  1  sink ready
out_data  out  DATA_W  passed-through word, or LRC on trailer beat
out_par  out  1  generate: computed parity; check: in_par echoed
out_lrc  out  1  1 on trailer beat
word_err  out  1  check mode: parity mismatch on this beat
frame_err  out  1  check mode: LRC mismatch, trailer beat only
clr_cnt  in  1  synchronous clear of err_cnt
err_cnt  out  ERR_CNT_W  saturating count of word_err + frame_err events

Behaviour:
- Reset (rst=1 at edge):
  - out_valid, out_data, out_par, out_lrc, word_err, frame_err and err_cnt are 0.
  - FSM goes to IDLE; LRC accumulator and word counter are 0.
  - in_ready=0 while rst=1.
  - Reset mid-frame discards the partial frame; no trailer is emitted.
- Parity: p = (^in_data) ^ mode_odd, so in_data plus p has an even (odd_sel=0) or odd (odd_sel=1) number of ones.
- Output register: single stage, 1-cycle latency from accept to out_valid.
  - in_ready = !out_valid | out_ready, except forced 0 in GEN_TRL.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
- FSM states:
  - IDLE: on accept, latch ctrl/odd_sel into mode regs, process word as DATA, cnt=1.
  - DATA: each accepted word: lrc ^= in_data, cnt++. When cnt reaches FRAME_LEN, go to GEN_TRL (gen) or CHK_TRL (check).
  - GEN_TRL: once the output register is free, load the trailer (out_data=lrc, out_par=parity(lrc) per mode, out_lrc=1), clear lrc/cnt, go to IDLE. in_ready=0 in this state.
  - CHK_TRL: next accepted beat is the received LRC. Output has out_lrc=1 and frame_err=(in_data != lrc); in_par is ignored and word_err=0. Then clear lrc/cnt and go to IDLE.
- Generate data beat: out_par=p, word_err=0, frame_err=0, out_lrc=0.
- Check data beat: out_par=in_par, word_err=(in_par != p).
- FRAME_LEN=1: every data word is immediately followed by a trailer.
- ctrl/odd_sel changes mid-frame have no effect until the next IDLE accept.
- err_cnt:
  - Increments by 1 on each output-register load with word_err or frame_err set (never both on one beat).
  - Saturates at all-ones.
  - clr_cnt wins over a simultaneous increment (result 0).

Decomposition:
- Package parity_stream_pkg holds:
  - FSM state enum (IDLE, DATA, GEN_TRL, CHK_TRL);
  - mode constants (MODE_GEN=0, MODE_CHK=1; PAR_EVEN=0, PAR_ODD=1).
- One combinational sub-module, parity_bit_calc (DATA_W, word, odd -> parity bit), used for both data-beat and trailer parity.
- FSM, accumulator, output register and counter stay in the top module.

Test Plan:
- All scenarios use DATA_W=8 and FRAME_LEN=4, with words 0x01, 0x03, 0x07, 0xFF.
- Generate even, ctrl=0, odd_sel=0 -> out_par 1,0,1,0, then a trailer with out_data=0xFA, out_par=0, out_lrc=1; in_ready=0 for the trailer cycle.
- Generate odd, odd_sel=1, same words -> out_par 0,1,0,1, trailer 0xFA with out_par=1.
- Check clean, ctrl=1, in_par 1,0,1,0, trailer in_data=0xFA -> word_err and frame_err always 0, err_cnt=0.
- Check corrupt: word 0x03 with in_par=1, trailer 0xFB -> word_err=1 on beat 2, frame_err=1 on trailer, err_cnt=2; then clr_cnt=1 -> err_cnt=0.
- Backpressure: out_ready=0 for 3 cycles after the first beat -> out_data=0x01 held stable, in_ready=0, no beat lost or duplicated, full frame plus trailer delivered.
- Reset mid-frame after 2 words -> all outputs 0, next 4 words produce trailer 0xFA. Separately, ERR_CNT_W=2 with 5 error events -> err_cnt=3.
